// File: rtl/id_ex_stage_reg.sv
// Decode->execute boundary register with load-use hazard detection; optional stats under IDEX_STATS_EN.
// Latency: 1 cycle D->E; a load-use hazard inserts exactly one bubble.
// Backpressure: StallE holds E; LoadUseStall (comb) tells fetch/decode to hold.
module id_ex_stage_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ValidD,
    input  logic                  RegWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  MemWriteD,
    input  logic                  JumpD,
    input  logic                  BranchD,
    input  logic [2:0]            ALUControlD,
    input  logic                  ALUSrcD,
    input  logic                  JalrmuxSelD,
    input  logic [2:0]            Funct3D,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [REG_AW-1:0]     Rs1D,
    input  logic [REG_AW-1:0]     Rs2D,
    input  logic [REG_AW-1:0]     RdD,
    input  logic                  FlushE,
    input  logic                  StallE,
    output logic                  ValidE,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic [2:0]            ALUControlE,
    output logic                  ALUSrcE,
    output logic                  JalrmuxSelE,
    output logic [2:0]            Funct3E,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [REG_AW-1:0]     Rs1E,
    output logic [REG_AW-1:0]     Rs2E,
    output logic [REG_AW-1:0]     RdE,
`ifdef IDEX_STATS_EN
    output logic [STAT_WIDTH-1:0] BubbleCnt,
    output logic [STAT_WIDTH-1:0] FlushCnt,
`endif
    output logic                  LoadUseStall
);

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic [2:0]            alu_control;
        logic                  alu_src;
        logic                  jalrmux_sel;
        logic [2:0]            funct3;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] imm_ext;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [REG_AW-1:0]     rs1;
        logic [REG_AW-1:0]     rs2;
        logic [REG_AW-1:0]     rd;
    } ex_t;

    ex_t ex_q, ex_d, ex_cap;

    // Empty decode slots still carry data, but must never carry side-effecting control.
    always_comb begin
        ex_cap             = '0;
        ex_cap.valid       = ValidD;
        ex_cap.reg_write   = ValidD & RegWriteD;
        ex_cap.result_src  = ValidD ? ResultSrcD  : 2'b00;
        ex_cap.mem_write   = ValidD & MemWriteD;
        ex_cap.jump        = ValidD & JumpD;
        ex_cap.branch      = ValidD & BranchD;
        ex_cap.alu_control = ValidD ? ALUControlD : 3'b000;
        ex_cap.alu_src     = ValidD & ALUSrcD;
        ex_cap.jalrmux_sel = ValidD & JalrmuxSelD;
        ex_cap.funct3      = Funct3D;
        ex_cap.rd1         = RD1D;
        ex_cap.rd2         = RD2D;
        ex_cap.imm_ext     = ImmExtD;
        ex_cap.pc          = PCD;
        ex_cap.pc_plus4    = PCPlus4D;
        ex_cap.rs1         = Rs1D;
        ex_cap.rs2         = Rs2D;
        ex_cap.rd          = RdD;
    end

    assign LoadUseStall = ex_q.valid & ex_q.reg_write & (ex_q.result_src == 2'b01)
                        & (ex_q.rd != '0) & ValidD
                        & ((ex_q.rd == Rs1D) | (ex_q.rd == Rs2D));

    always_comb begin
        ex_d = ex_q;
        if (FlushE)            ex_d = '0;
        else if (StallE)       ex_d = ex_q;
        else if (LoadUseStall) ex_d = '0;
        else                   ex_d = ex_cap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

`ifdef IDEX_STATS_EN
    localparam logic [STAT_WIDTH-1:0] CNT_ONE = STAT_WIDTH'(1);
    logic [STAT_WIDTH-1:0] bubble_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (!FlushE && !StallE && LoadUseStall) bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
            if (FlushE && (ex_q.valid || ValidD))  flush_cnt_q  <= flush_cnt_q + CNT_ONE;
        end
    end

    assign BubbleCnt = bubble_cnt_q;
    assign FlushCnt  = flush_cnt_q;
`endif

    assign ValidE      = ex_q.valid;
    assign RegWriteE   = ex_q.reg_write;
    assign ResultSrcE  = ex_q.result_src;
    assign MemWriteE   = ex_q.mem_write;
    assign JumpE       = ex_q.jump;
    assign BranchE     = ex_q.branch;
    assign ALUControlE = ex_q.alu_control;
    assign ALUSrcE     = ex_q.alu_src;
    assign JalrmuxSelE = ex_q.jalrmux_sel;
    assign Funct3E     = ex_q.funct3;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign ImmExtE     = ex_q.imm_ext;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc_plus4;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;

endmodule
